// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes,
// instruction classes and the datapath control codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ClsNone = 3'd0,
        ClsR    = 3'd1,
        ClsI    = 3'd2,
        ClsLd   = 3'd3,
        ClsSt   = 3'd4,
        ClsBr   = 3'd5,
        ClsJal  = 3'd6
    } cls_e;

    localparam logic [6:0] OpcR   = 7'b0110011;
    localparam logic [6:0] OpcI   = 7'b0010011;
    localparam logic [6:0] OpcLd  = 7'b0000011;
    localparam logic [6:0] OpcSt  = 7'b0100011;
    localparam logic [6:0] OpcBr  = 7'b1100011;
    localparam logic [6:0] OpcJal = 7'b1101111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;
    localparam logic [2:0] AluSll = 3'b110;
    localparam logic [2:0] AluSrl = 3'b111;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    localparam logic [1:0] WdAlu  = 2'b00;
    localparam logic [1:0] WdDmem = 2'b01;
    localparam logic [1:0] WdPc4  = 2'b10;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseImem    = 2'b10;
    localparam logic [1:0] CauseDmem    = 2'b11;

    // Wait counter width; it saturates, so wait limits beyond its range never fire.
    localparam int unsigned CntW = 16;

    // Map an opcode to its instruction class; unsupported opcodes give ClsNone.
    function automatic cls_e decode_class(input logic [6:0] opc);
        cls_e cls;
        case (opc)
            OpcR:    cls = ClsR;
            OpcI:    cls = ClsI;
            OpcLd:   cls = ClsLd;
            OpcSt:   cls = ClsSt;
            OpcBr:   cls = ClsBr;
            OpcJal:  cls = ClsJal;
            default: cls = ClsNone;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode for R- and I-type classes from funct3/funct7[5].
module alu_decoder
    import ctrl_pkg::*;
(
    input  cls_e       cls_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [2:0] alu_ctrl_o
);

    // funct3 lookup; only R-type honours funct7[5] for SUB (I-type has no SUBI).
    always_comb begin
        alu_ctrl_o = AluAdd;
        if (cls_i == ClsR || cls_i == ClsI) begin
            case (funct3_i)
                3'b000:  alu_ctrl_o = (cls_i == ClsR && funct7_5_i) ? AluSub : AluAdd;
                3'b111:  alu_ctrl_o = AluAnd;
                3'b110:  alu_ctrl_o = AluOr;
                3'b100:  alu_ctrl_o = AluXor;
                3'b010:  alu_ctrl_o = AluSlt;
                3'b001:  alu_ctrl_o = AluSll;
                3'b101:  alu_ctrl_o = AluSrl;
                default: alu_ctrl_o = AluAdd;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM sequencing the RV32I datapath through
// fetch / decode / execute / memory / writeback, with a sticky trap state.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned IMEM_WAIT_MAX = 15,
    parameter int unsigned DMEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        alu_zero,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_en,
    output logic        jmp,
    output logic        dmem_req,
    output logic        wr_en_mem,
    output logic        wr_en_reg,
    output logic        alu_op_b_src,
    output logic [2:0]  immFormat,
    output logic [2:0]  aluCTRL,
    output logic [1:0]  reg_wd_sel,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    state_e          state_q, state_d;
    cls_e            cls_q, cls_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;

    logic [CntW-1:0] cnt_inc;
    logic [31:0]     cnt_next;
    logic            imem_tmo;
    logic            dmem_tmo;
    logic [2:0]      dec_alu;
    logic            unused_instr;

    assign unused_instr = ^{instr[31], instr[29:15]};

    alu_decoder u_alu_decoder (
        .cls_i      (cls_q),
        .funct3_i   (instr[14:12]),
        .funct7_5_i (instr[30]),
        .alu_ctrl_o (dec_alu)
    );

    // Saturating increment and timeout detection; a limit of 0 disables the timeout.
    always_comb begin
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
        cnt_next = 32'(cnt_q) + 32'd1;
        imem_tmo = (IMEM_WAIT_MAX != 0) && (cnt_next >= IMEM_WAIT_MAX);
        dmem_tmo = (DMEM_WAIT_MAX != 0) && (cnt_next >= DMEM_WAIT_MAX);
    end

    // Next-state, decode-class latch, wait counter and trap cause.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    state_d = StDecode;
                end else if (imem_tmo) begin
                    state_d = StTrap;
                    cause_d = CauseImem;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDecode: begin
                cls_d = decode_class(instr[6:0]);
                if (cls_d == ClsNone) begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsR, ClsI, ClsJal: state_d = StWb;
                    ClsLd, ClsSt:       state_d = StMem;
                    ClsBr:              state_d = StFetch;
                    default: begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
                endcase
            end
            StMem: begin
                if (dmem_ready) begin
                    state_d = (cls_q == ClsSt) ? StFetch : StWb;
                end else if (dmem_tmo) begin
                    state_d = StTrap;
                    cause_d = CauseDmem;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Datapath controls decoded from registered state and class.
    // Gated by rst so nothing is driven (and no write escapes) while reset is held.
    always_comb begin
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        jmp          = 1'b0;
        dmem_req     = 1'b0;
        wr_en_mem    = 1'b0;
        wr_en_reg    = 1'b0;
        alu_op_b_src = 1'b0;
        immFormat    = ImmI;
        aluCTRL      = AluAdd;
        reg_wd_sel   = WdAlu;
        trap         = 1'b0;
        trap_cause   = CauseNone;
        if (rst) begin
            case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ready;
                end
                StExec: begin
                    alu_op_b_src = (cls_q == ClsI) || (cls_q == ClsLd) || (cls_q == ClsSt);
                    case (cls_q)
                        ClsSt:   immFormat = ImmS;
                        ClsBr:   immFormat = ImmB;
                        ClsJal:  immFormat = ImmJ;
                        default: immFormat = ImmI;
                    endcase
                    case (cls_q)
                        ClsLd, ClsSt: aluCTRL = AluAdd;
                        ClsBr:        aluCTRL = AluSub;
                        default:      aluCTRL = dec_alu;
                    endcase
                    if (cls_q == ClsBr) begin
                        pc_en = 1'b1;
                        jmp   = alu_zero;
                    end
                end
                StMem: begin
                    dmem_req  = 1'b1;
                    wr_en_mem = (cls_q == ClsSt);
                    pc_en     = dmem_ready && (cls_q == ClsSt);
                end
                StWb: begin
                    wr_en_reg = (instr[11:7] != 5'd0);
                    pc_en     = 1'b1;
                    jmp       = (cls_q == ClsJal);
                    case (cls_q)
                        ClsLd:   reg_wd_sel = WdDmem;
                        ClsJal:  reg_wd_sel = WdPc4;
                        default: reg_wd_sel = WdAlu;
                    endcase
                end
                StTrap: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            cls_q   <= ClsNone;
            cnt_q   <= '0;
            cause_q <= CauseNone;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the RV32I datapath: fetch, decode, execute, memory, writeback. Drives the datapath controls wr_en_reg, wr_en_mem, jmp, alu_op_b_src, immFormat, aluCTRL and reg_wd_sel. It also generates the PC and IR load strobes and handshakes with the instruction and data memories. Supported subset: R-type ALU, I-type ALU, LW, SW, BEQ, JAL. Any other opcode traps.

Parameters:
IMEM_WAIT_MAX, 15, cycles spent waiting for imem_ready before a fetch timeout trap (0 disables the timeout)
DMEM_WAIT_MAX, 15, same timeout for dmem_ready

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
instr  in  32  IR contents, stable from DECODE onward
imem_ready  in  1  instruction memory has data valid this cycle
dmem_ready  in  1  data memory access completes this cycle
alu_zero  in  1  ALU result == 0
imem_req  out  1  instruction fetch request
ir_load  out  1  capture instruction into IR
pc_en  out  1  update PC (PC+4, or target when jmp=1)
jmp  out  1  select branch/jump target for the PC
dmem_req  out  1  data memory request
wr_en_mem  out  1  data memory write
wr_en_reg  out  1  register file write
alu_op_b_src  out  1  0 = rs2, 1 = immExt
immFormat  out  3  000 I, 001 S, 010 B, 011 J, 100 U
aluCTRL  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
reg_wd_sel  out  2  00 ALU, 01 dmem, 10 PC+4
trap  out  1  sticky error flag
trap_cause  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout

Behaviour:
- Reset:
  - While rst=0: state=FETCH, class=NONE, wait counter=0, trap=0, trap_cause=00, and every output 0.
  - The first rising edge after release already has imem_req=1.
  - Reset asserted mid-instruction aborts it; no partial writes occur after reset is asserted.
- Output timing: all outputs are combinational from registered state and the registered decode class. Outputs not listed for a state are 0.
- States:
  - FETCH:
    - imem_req=1.
    - When imem_ready: ir_load=1 for that cycle, go to DECODE.
    - Otherwise increment the wait counter. At IMEM_WAIT_MAX go to TRAP with cause 10.
  - DECODE:
    - Latch class from instr[6:0]: 0110011 R, 0010011 I, 0000011 LD, 0100011 ST, 1100011 BR, 1101111 JAL.
    - Any other opcode goes to TRAP with cause 01.
    - Otherwise go to EXEC.
  - EXEC:
    - alu_op_b_src = 1 for I, LD and ST.
    - immFormat per class; aluCTRL from the alu_decoder.
    - R and I go to WB.
    - LD and ST go to MEM with aluCTRL = ADD.
    - BR: aluCTRL = SUB, pc_en=1, jmp=alu_zero, then FETCH.
    - JAL goes to WB.
  - MEM:
    - dmem_req=1, and wr_en_mem=1 for ST, both held until dmem_ready.
    - On dmem_ready, ST: pc_en=1, then FETCH. LD: go to WB.
    - Timeout uses the same counter rules as FETCH, with cause 11.
  - WB:
    - wr_en_reg = (instr[11:7] != 0); x0 is never written.
    - reg_wd_sel: 00 for R/I, 01 for LD, 10 for JAL.
    - pc_en=1, with jmp=1 for JAL. Then FETCH.
  - TRAP:
    - trap=1 and trap_cause held.
    - All other outputs 0. Only reset exits this state.
- Wait counter: clears on every state change and saturates; it never wraps.
- Exactly one pc_en pulse per retired instruction. No pc_en is issued for an instruction that traps.
- Cycle counts with zero-wait memory: R/I 4, LW 5, SW 4, BEQ 3, JAL 4. Each memory wait cycle adds 1.
- ALU decode:
  - R-type: funct3 000 gives ADD, or SUB when funct7[5]=1. 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL.
  - I-type: same mapping, except funct3 000 is always ADD.

Decomposition:
- ctrl_pkg holds:
  - state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
  - opcode constants
  - instruction class encoding
  - aluCTRL, immFormat, reg_wd_sel and trap_cause codes
- One combinational sub-module, alu_decoder: inputs class, funct3, funct7[5]; output aluCTRL.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), zero-wait memory → DECODE/EXEC/WB follow FETCH. In WB: wr_en_reg=1, reg_wd_sel=00, aluCTRL=000, alu_op_b_src=0, pc_en=1. Next fetch is 4 cycles after the first.
- LW x5,8(x1) (0x0080A283), dmem_ready delayed 2 cycles → dmem_req high 3 cycles with wr_en_mem=0, then WB with reg_wd_sel=01, wr_en_reg=1. Total 7 cycles.
- SW x5,12(x1) (0x0050A623) → in EXEC: immFormat=001, alu_op_b_src=1. In MEM: wr_en_mem=1. wr_en_reg never asserts. pc_en pulses on dmem_ready.
- BEQ x1,x2,+8 (0x00208463), run twice → alu_zero=1 gives pc_en=1, jmp=1 in EXEC. alu_zero=0 gives pc_en=1, jmp=0. aluCTRL=001 and immFormat=010 in both cases. 3 cycles each.
- Illegal instruction 0xFFFFFFFF → trap=1, trap_cause=01 the cycle after DECODE; all strobes 0 for 20+ cycles. After rst pulse: trap=0 and imem_req=1.
- imem_ready held 0 → trap_cause=10 after 15 FETCH cycles. Separately, assert rst during MEM of a SW → wr_en_mem drops immediately and state returns to FETCH.
